i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

Synthesizable I2C target (slave) that answers a 7-bit address and exposes a 2^ADDR_W × 8-bit register file over the bus. It is the bus-side counterpart of our `i2c_master`. It stands in for the CMPS2 in hardware-in-the-loop builds, and it lets a second FPGA image present compass data to an external I2C host. Supported sequences:

- Write: START, address+W, register pointer, data bytes, STOP.
- Read: START, address+W, pointer, repeated START, address+R, data bytes, NACK, STOP.

## Interface
Parameters:
- DEV_ADDR, 7'h30, 7-bit address this target responds to.
- ADDR_W, 4, register pointer width; register file depth is 2^ADDR_W.

Ports:
- clk  in  1  system clock (100 MHz nominal); must be ≥ 20× SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release. The top level ties the pad as `sda = sda_oe ? 0 : z`.
- host_we  in  1  local write strobe into the register file.
- host_addr  in  ADDR_W  local read/write address.
- host_wdata  in  8  local write data.
- host_rdata  out  8  reg[host_addr], registered with 1-cycle latency.
- bus_we  out  1  1-cycle pulse when a bus write commits a byte.
- bus_waddr  out  ADDR_W  register address written by the bus, valid with bus_we.
- bus_wdata  out  8  byte written by the bus, valid with bus_we.
- busy  out  1  high from an addressed START until STOP or NACK-release.

## Operation
- **Synchronizer:** scl_in and sda_in each pass through 2 flip-flops, then a 1-flop history register for edge detection. No other glitch filter.
- **START:** synced SDA 1→0 while synced SCL = 1, accepted in any state including mid-byte. Go to ADDR; bit counter = 0; release SDA.
- **STOP:** synced SDA 0→1 while SCL = 1. Go to IDLE; release SDA; busy = 0.
- Priority within one cycle: rst > START/STOP > SCL edge.
- **Bit timing:** bits are sampled on the synced SCL rising edge. The target changes sda_oe only on the synced SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK.
  - **ADDR:** shift in 8 bits MSB first.
    - If bits[7:1] == DEV_ADDR, assert sda_oe on that falling edge and go to ADDR_ACK; busy = 1.
    - On mismatch, go to IDLE with SDA released.
  - **ADDR_ACK:** on the falling edge ending the ACK:
    - R/W = 0: go to PTR and release SDA.
    - R/W = 1: load shift = reg[ptr], ptr ← ptr+1, drive bit7 (sda_oe = ~bit7), go to RDATA.
  - **PTR:** 8 bits received; ptr ← low ADDR_W bits; ACK; → PTR_ACK → WDATA.
  - **WDATA:** 8 bits received; reg[ptr] ← byte; pulse bus_we with bus_waddr = ptr (pre-increment); ptr ← ptr+1; ACK → WDATA_ACK → WDATA.
  - **RDATA:** drive bits 6..0 on successive falling edges. After the 8th falling edge, release SDA → RD_MACK.
  - **RD_MACK:** sample SDA on the rising edge.
    - ACK (0): on the falling edge, load the next byte and post-increment ptr as in ADDR_ACK, then → RDATA.
    - NACK (1): release SDA, → IDLE, busy = 0.
- **Pointer:** wraps modulo 2^ADDR_W. The pointer persists across transactions, so address+R with no pointer byte reads from the current ptr.
- **Write collision:** if host_we and a bus write hit the same register in the same cycle, the bus write wins. On different addresses, both writes land.
- **Reset:**
  - Values: all registers 0, ptr 0, state IDLE, sda_oe 0, bus_we 0, bus_waddr 0, bus_wdata 0, busy 0, host_rdata 0.
  - Reset mid-transaction releases SDA on the next clk edge. The target then ignores the bus until the next START.

## Timing
- Pin edge to sync edge-detect: 3 clk.
- sda_oe update: 1 clk after the detected SCL falling edge, so ≤ 4 clk after the pin edge.
- At 100 MHz / 400 kHz this gives ≥ 100 clk per SCL low phase, so data-hold and setup margins are met.
- bus_we: asserted the clk after the falling edge that begins the ACK, for exactly 1 cycle.
- host_rdata: reflects a bus write 1 clk after bus_we.
- Read byte content: captured from reg[ptr] at the falling edge that starts the byte. A host_we later in that byte does not alter bits already shifting out.

## Test plan
- **Register write:** master writes 0xBE to reg 0x05 → ACK on all 3 bytes; one bus_we pulse with bus_waddr = 5, bus_wdata = 0xBE; host_rdata(5) = 0xBE; ptr = 6.
- **Burst read:** host preloads reg 3..5 = 0xA5, 0x00, 0xFF; master sets ptr 3, repeated START, reads 3 bytes with ACK, ACK, NACK → returns A5, 00, FF; SDA released after NACK; busy = 0.
- **Pointer wrap:** burst write 0x11, 0x22 starting at ptr 15 → reg15 = 0x11, reg0 = 0x22; bus_waddr sequence 15, 0.
- **Address mismatch:** master addresses 0x31 → SDA never driven (sda_oe stays 0 for the whole transaction); master reports error; registers unchanged; busy = 0.
- **Reset mid-read:** rst asserted while driving a 0 bit → sda_oe = 0 the next clk; rest of transfer ignored; next full write to reg 0x02 succeeds.
- **Collision:** host_we and bus write to reg 7 in the same cycle (host 0x12, bus 0x34) → reg7 = 0x34.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing a 2^ADDR_W x 8 register file
`timescale 1ns/1ps
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h30,
  parameter int         ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_waddr,
  output logic [7:0]        bus_wdata,
  output logic              busy
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_hist, sda_hist;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [7:0]        shift, shift_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              sda_oe_d, busy_d, mack, mack_d;
  logic              bus_we_d;
  logic [ADDR_W-1:0] bus_waddr_d;
  logic [7:0]        bus_wdata_d;
  logic              commit;
  logic [7:0]        rd_byte;

  logic [7:0] regs [DEPTH];

  // Idle bus level on reset so that no edge is seen while the flops refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  assign start_det = scl_s & sda_hist & ~sda_s;
  assign stop_det  = scl_s & ~sda_hist & sda_s;
  assign rd_byte   = regs[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      mack      <= 1'b1;
      bus_we    <= 1'b0;
      bus_waddr <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shift     <= shift_d;
      ptr       <= ptr_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      mack      <= mack_d;
      bus_we    <= bus_we_d;
      bus_waddr <= bus_waddr_d;
      bus_wdata <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shift_d     = shift;
    ptr_d       = ptr;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    mack_d      = mack;
    bus_we_d    = 1'b0;
    bus_waddr_d = bus_waddr;
    bus_wdata_d = bus_wdata;
    commit      = 1'b0;

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (cnt != 4'd8) begin
            shift_d = {shift[6:0], sda_s};
            cnt_d   = cnt + 4'd1;
          end
        end
        RD_MACK: mack_d = sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR: begin
          if (cnt == 4'd8) begin
            if (shift[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (shift[0]) begin
            shift_d  = rd_byte;
            ptr_d    = ptr + PTR_ONE;
            sda_oe_d = ~rd_byte[7];
            cnt_d    = '0;
            state_d  = RDATA;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = PTR;
          end
        end
        PTR: begin
          if (cnt == 4'd8) begin
            ptr_d    = shift[ADDR_W-1:0];
            sda_oe_d = 1'b1;
            state_d  = PTR_ACK;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          sda_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = WDATA;
        end
        WDATA: begin
          if (cnt == 4'd8) begin
            commit      = 1'b1;
            bus_we_d    = 1'b1;
            bus_waddr_d = ptr;
            bus_wdata_d = shift;
            ptr_d       = ptr + PTR_ONE;
            sda_oe_d    = 1'b1;
            state_d     = WDATA_ACK;
          end
        end
        RDATA: begin
          // Bit 7 went out on the load; seven more falling edges shift bits 6..0.
          if (cnt == 4'd7) begin
            sda_oe_d = 1'b0;
            mack_d   = 1'b1;
            state_d  = RD_MACK;
          end else begin
            sda_oe_d = ~shift[6];
            shift_d  = {shift[6:0], 1'b0};
            cnt_d    = cnt + 4'd1;
          end
        end
        RD_MACK: begin
          if (!mack) begin
            shift_d  = rd_byte;
            ptr_d    = ptr + PTR_ONE;
            sda_oe_d = ~rd_byte[7];
            cnt_d    = '0;
            state_d  = RDATA;
          end else begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus write is issued after the host write so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      host_rdata <= '0;
    end else begin
      host_rdata <= regs[host_addr];
      if (host_we) regs[host_addr] <= host_wdata;
      if (commit)  regs[ptr] <= shift;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - randomized bench with a byte-level register file model
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam logic [6:0] DEV = 7'h30;
  localparam int         Q   = 80;

  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda_low = 1'b0;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       sda_oe, bus_we, busy;
  logic [3:0] bus_waddr;
  logic [7:0] bus_wdata, host_rdata;
  wire        sda_line = ~(m_sda_low | sda_oe);

  i2c_target_regfile #(.DEV_ADDR(DEV), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .bus_we(bus_we), .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_fail = 0;
  logic [7:0]  mregs [16];
  logic [3:0]  mptr = '0;
  logic [11:0] wq [$];
  bit          quiet = 1'b1;
  logic        prev_we = 1'b0;
  logic [7:0]  txd [4];
  logic [7:0]  rxd [4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle checks: every bus write pulse against the model queue, and SDA never driven when quiet.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_we) begin
        check("bus_we single cycle", int'(prev_we), 0);
        if (wq.size() == 0) check("bus_we unexpected", 1, 0);
        else begin
          logic [11:0] e;
          e = wq.pop_front();
          check("bus_waddr", int'(bus_waddr), int'(e[11:8]));
          check("bus_wdata", int'(bus_wdata), int'(e[7:0]));
        end
      end
      if (quiet) check("sda_oe released", int'(sda_oe), 0);
    end
    prev_we = bus_we;
  end

  task automatic write_bit(input logic b);
    #(Q); m_sda_low = ~b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #(Q); m_sda_low = 1'b0; #(Q); scl = 1'b1; #(Q); b = sda_line; #(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    #(Q); m_sda_low = 1'b0; #(Q); scl = 1'b1; #(Q); m_sda_low = 1'b1; #(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #(Q); m_sda_low = 1'b1; #(Q); scl = 1'b1; #(Q); m_sda_low = 1'b0; #(Q);
  endtask

  // With collide set, the last SCL fall is clock-aligned so a host write to reg 7 meets the commit cycle.
  task automatic write_byte(input logic [7:0] b, input bit collide, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && collide) begin
        #(Q); m_sda_low = ~b[0]; #(Q); scl = 1'b1; #(2*Q);
        @(negedge clk); scl = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h12;
        @(negedge clk); host_we = 1'b0;
      end else begin
        write_bit(b[i]);
      end
    end
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      read_bit(x);
      b[i] = x;
    end
    write_bit(mack);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); host_we = 1'b1; host_addr = a; host_wdata = d;
    mregs[a] = d;
    @(negedge clk); host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); host_addr = a;
    @(negedge clk); d = host_rdata;
  endtask

  task automatic host_check(input logic [3:0] a);
    logic [7:0] d;
    host_read(a, d);
    check($sformatf("host_rdata[%0d]", a), int'(d), int'(mregs[a]));
  endtask

  task automatic bus_write(input logic [7:0] p, input int n, input bit collide);
    logic ack;
    quiet = 1'b0;
    i2c_start();
    write_byte({DEV, 1'b0}, 1'b0, ack);
    check("addr ack (write)", int'(ack), 0);
    check("busy after address", int'(busy), 1);
    write_byte(p, 1'b0, ack);
    check("pointer ack", int'(ack), 0);
    mptr = p[3:0];
    for (int i = 0; i < n; i++) begin
      wq.push_back({mptr, txd[i]});
      if (collide) mregs[7] = 8'h12;
      mregs[mptr] = txd[i];
      mptr = mptr + 4'd1;
      write_byte(txd[i], collide, ack);
      check("data ack", int'(ack), 0);
    end
    i2c_stop();
    check("busy after stop", int'(busy), 0);
    check("bus writes pending", wq.size(), 0);
    quiet = 1'b1;
  endtask

  task automatic bus_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    quiet = 1'b0;
    i2c_start();
    if (set_ptr) begin
      write_byte({DEV, 1'b0}, 1'b0, ack);
      check("addr ack (ptr)", int'(ack), 0);
      write_byte(p, 1'b0, ack);
      check("pointer ack", int'(ack), 0);
      mptr = p[3:0];
      i2c_start();
    end
    write_byte({DEV, 1'b1}, 1'b0, ack);
    check("addr ack (read)", int'(ack), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      rxd[i] = b;
      check($sformatf("read byte %0d", i), int'(b), int'(mregs[mptr]));
      mptr = mptr + 4'd1;
    end
    check("sda_oe after nack", int'(sda_oe), 0);
    i2c_stop();
    check("busy after read", int'(busy), 0);
    quiet = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic       ack, x;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;

    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("reset sda_oe", int'(sda_oe), 0);
    check("reset busy", int'(busy), 0);
    check("reset bus_we", int'(bus_we), 0);
    check("reset bus_waddr", int'(bus_waddr), 0);
    check("reset bus_wdata", int'(bus_wdata), 0);
    check("reset host_rdata", int'(host_rdata), 0);

    // Register write, then a pointer-less read must come from reg 6.
    host_write(4'd6, 8'h66);
    txd[0] = 8'hBE;
    bus_write(8'h05, 1, 1'b0);
    host_read(4'd5, d);
    check("reg5 after write", int'(d), 'hBE);
    bus_read(1'b0, 8'h00, 1);
    check("read from ptr 6", int'(rxd[0]), 'h66);

    // Burst read.
    host_write(4'd3, 8'hA5);
    host_write(4'd4, 8'h00);
    host_write(4'd5, 8'hFF);
    bus_read(1'b1, 8'h03, 3);
    check("burst byte0", int'(rxd[0]), 'hA5);
    check("burst byte1", int'(rxd[1]), 'h00);
    check("burst byte2", int'(rxd[2]), 'hFF);

    // Pointer wrap.
    txd[0] = 8'h11; txd[1] = 8'h22;
    bus_write(8'h0F, 2, 1'b0);
    host_read(4'd15, d);
    check("reg15 after wrap", int'(d), 'h11);
    host_read(4'd0, d);
    check("reg0 after wrap", int'(d), 'h22);

    // Address mismatch: every byte NACKed, nothing written.
    i2c_start();
    write_byte({7'h31, 1'b0}, 1'b0, ack);
    check("mismatch addr nack", int'(ack), 1);
    write_byte(8'h05, 1'b0, ack);
    check("mismatch ptr nack", int'(ack), 1);
    write_byte(8'h99, 1'b0, ack);
    check("mismatch data nack", int'(ack), 1);
    i2c_stop();
    check("mismatch busy", int'(busy), 0);
    host_check(4'd5);

    // Collision on reg 7.
    txd[0] = 8'h34;
    bus_write(8'h07, 1, 1'b1);
    host_read(4'd7, d);
    check("reg7 after collision", int'(d), 'h34);

    // Reset while the target drives a 0 bit.
    host_write(4'd9, 8'h0F);
    quiet = 1'b0;
    i2c_start();
    write_byte({DEV, 1'b0}, 1'b0, ack);
    write_byte(8'h09, 1'b0, ack);
    i2c_start();
    write_byte({DEV, 1'b1}, 1'b0, ack);
    check("addr ack before reset", int'(ack), 0);
    #(Q);
    @(negedge clk);
    check("sda_oe driving bit7", int'(sda_oe), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("sda_oe after reset", int'(sda_oe), 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = '0;
    wq.delete();
    quiet = 1'b1;
    #(Q); scl = 1'b1; #(2*Q); scl = 1'b0;
    for (int i = 0; i < 7; i++) read_bit(x);
    write_bit(1'b1);
    i2c_stop();
    check("busy after reset", int'(busy), 0);
    txd[0] = 8'h5A;
    bus_write(8'h02, 1, 1'b0);
    host_read(4'd2, d);
    check("reg2 after reset", int'(d), 'h5A);

    // Randomized traffic against the model.
    for (int t = 0; t < 12; t++) begin
      int op, n;
      logic [7:0] p;
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 3);
      p  = 8'($urandom);
      case (op)
        0: begin
          for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
          bus_write(p, n, 1'b0);
        end
        1: bus_read(1'b1, p, n);
        2: bus_read(1'b0, p, n);
        default: begin
          host_write(4'($urandom), 8'($urandom));
          host_check(4'($urandom));
        end
      endcase
    end

    for (int i = 0; i < 16; i++) host_check(4'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
